// File: rtl/vga_sram_scheduler.sv
// Shares one asynchronous SRAM between the VGA display path (even slots) and the CPU port (remaining slots),
// and owns double-buffer front/back selection with swaps at the end of the active frame.
module vga_sram_scheduler #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              pix_en,
    input  logic              disp_vactive,
    input  logic              disp_req,
    input  logic [ADDR_W-2:0] disp_addr,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic              cpu_we,
    input  logic [ADDR_W-2:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [1:0]        cpu_be,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              swap_req,
    output logic              front_buf,
    output logic              swap_done,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRD,
        ST_CRD,
        ST_CWR
    } state_e;

    state_e              state;
    state_e              state_nxt;
    logic                phase;
    logic                grant_disp;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   dq_o_nxt;
    logic                ce_nxt;
    logic                oe_nxt;
    logic                we_nxt;
    logic                ub_nxt;
    logic                lb_nxt;
    logic                dq_oe_nxt;
    logic                vact_q;
    logic                vact_fall;
    logic                pending;

    // Slot phase: even slots (phase 0) belong to the display and pace the timing generator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 1'b0;
        end else begin
            phase <= ~phase;
        end
    end

    assign pix_en     = ~phase;
    assign grant_disp = ~phase & disp_req;
    assign cpu_ready  = cpu_valid & (phase | ~disp_req);

    // Issue state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant arbitration, address composition and next SRAM strobes.
    always_comb begin
        state_nxt = ST_IDLE;
        addr_nxt  = sram_addr;
        dq_o_nxt  = sram_dq_o;
        ce_nxt    = 1'b1;
        oe_nxt    = 1'b1;
        we_nxt    = 1'b1;
        ub_nxt    = 1'b1;
        lb_nxt    = 1'b1;
        dq_oe_nxt = 1'b0;

        if (grant_disp) begin
            state_nxt = ST_DRD;
            addr_nxt  = {front_buf, disp_addr};
        end else if (cpu_valid) begin
            state_nxt = cpu_we ? ST_CWR : ST_CRD;
            addr_nxt  = {~front_buf, cpu_addr};
            if (cpu_we) begin
                dq_o_nxt = cpu_wdata;
            end
        end

        case (state_nxt)
            ST_DRD, ST_CRD: begin
                ce_nxt = 1'b0;
                oe_nxt = 1'b0;
                ub_nxt = 1'b0;
                lb_nxt = 1'b0;
            end
            ST_CWR: begin
                ce_nxt    = 1'b0;
                we_nxt    = 1'b0;
                ub_nxt    = ~cpu_be[1];
                lb_nxt    = ~cpu_be[0];
                dq_oe_nxt = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Registered SRAM pins; dq_oe and oe_n switch on the same edge, the slot covers tWHZ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
        end else begin
            sram_addr  <= addr_nxt;
            sram_dq_o  <= dq_o_nxt;
            sram_dq_oe <= dq_oe_nxt;
            sram_ce_n  <= ce_nxt;
            sram_oe_n  <= oe_nxt;
            sram_we_n  <= we_nxt;
            sram_ub_n  <= ub_nxt;
            sram_lb_n  <= lb_nxt;
        end
    end

    // Read return: capture on the edge that ends a read slot, steered by the state tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_rdata  <= '0;
            disp_rvalid <= 1'b0;
            cpu_rdata   <= '0;
            cpu_rvalid  <= 1'b0;
        end else begin
            disp_rvalid <= (state == ST_DRD);
            cpu_rvalid  <= (state == ST_CRD);
            if (state == ST_DRD) begin
                disp_rdata <= sram_dq_i;
            end
            if (state == ST_CRD) begin
                cpu_rdata <= sram_dq_i;
            end
        end
    end

    assign vact_fall = vact_q & ~disp_vactive;

    // Double-buffer swap, taken only at the end of the active frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vact_q    <= 1'b0;
            pending   <= 1'b0;
            front_buf <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            vact_q    <= disp_vactive;
            swap_done <= 1'b0;
            if (vact_fall && (pending || swap_req)) begin
                front_buf <= ~front_buf;
                pending   <= 1'b0;
                swap_done <= 1'b1;
            end else if (swap_req) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: doc/vga_sram_scheduler.md
# vga_sram_scheduler

Time-slot scheduler that shares the board's single 16-bit asynchronous SRAM between the VGA display path and the drawing engine (CPU port). It runs at twice the pixel rate. It generates the pixel-clock enable that paces the VGA timing generator, reserves every even slot for display reads, and grants all remaining slots to the CPU port. It also owns double-buffer frame selection, swapping front/back buffers only at the end of the active frame.

## Interface
- ADDR_W, 20, SRAM word-address width; MSB selects frame buffer
- DATA_W, 16, SRAM data width
- clk  in  1  2x pixel clock (50 MHz)
- rst_n  in  1  reset, asynchronous, active-low
- pix_en  out  1  pixel-clock enable for the timing generator; high in even slots
- disp_vactive  in  1  timing generator's vertical-active request
- disp_req  in  1  display read request, sampled only in even slots
- disp_addr  in  ADDR_W-1  pixel word address within the front buffer
- disp_rdata  out  DATA_W  display read data
- disp_rvalid  out  1  one-cycle strobe qualifying disp_rdata
- cpu_valid / cpu_ready  in / out  1  CPU request handshake
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W-1  word address within the back buffer
- cpu_wdata  in  DATA_W  write data
- cpu_be  in  2  byte enables for writes, active-high
- cpu_rdata / cpu_rvalid  out  DATA_W / 1  CPU read data and strobe
- swap_req  in  1  one-cycle pulse requesting a buffer swap
- front_buf  out  1  buffer currently displayed
- swap_done  out  1  one-cycle pulse when a swap takes effect
- sram_addr  out  ADDR_W  SRAM address
- sram_dq_o / sram_dq_oe / sram_dq_i  out / out / in  DATA_W / 1 / DATA_W  split tristate; the top level builds the pad
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes, active-low

## Operation
- **Phase register:** `phase` toggles every clk, starting from 0. pix_en = (phase==0). Even slot means phase==0.
- **Grant per cycle:**
  - DISP if phase==0 && disp_req.
  - Otherwise CPU if cpu_valid.
  - Otherwise IDLE.
- **CPU handshake:** cpu_ready = cpu_valid && (phase==1 || !disp_req), combinational. Transfer occurs on an edge where cpu_valid && cpu_ready. The CPU must hold valid, we, addr, wdata and be stable until that edge.
- **Display timing:** a disp_req presented in an odd slot is ignored; the display source is paced by pix_en. The display is never stalled.
- **Issue state machine:** ST_IDLE, ST_DRD, ST_CRD, ST_CWR, registered from the grant. Outputs are registered in that state:
  - ST_IDLE: ce/oe/we/ub/lb = 1, dq_oe = 0.
  - ST_DRD / ST_CRD: ce=0, oe=0, we=1, ub=lb=0, dq_oe=0.
  - ST_CWR: ce=0, oe=1, we=0, ub/lb = ~cpu_be, dq_oe=1, dq_o = wdata.
- **Address composition:**
  - DISP: sram_addr = {front_buf, disp_addr}.
  - CPU: sram_addr = {~front_buf, cpu_addr}.
- **Read return:** sram_dq_i is captured on the edge that ends a read state. The data goes to disp_rdata or cpu_rdata according to the source tag, with the matching rvalid high for one cycle. The idle side's rdata holds its previous value.
- **Buffer swap:**
  - `pending` is set by swap_req.
  - On the falling edge of disp_vactive (registered compare): if pending || swap_req, then front_buf toggles, pending clears, and swap_done pulses.
  - Repeated swap_req while pending has no extra effect.
  - If swap_req coincides with the falling edge, the swap happens at that edge.
- Back-to-back write then read needs no idle cycle. dq_oe and oe_n change on the same edge; SRAM tWHZ is covered by the 20 ns slot.

## Timing
- **Reset values:**
  - phase = 0, so pix_en = 1 during reset.
  - State ST_IDLE; all SRAM strobes = 1; dq_oe = 0; sram_addr = 0; dq_o = 0.
  - disp_rdata = cpu_rdata = 0; disp_rvalid = cpu_rvalid = 0.
  - front_buf = 0; pending = 0; swap_done = 0; the disp_vactive history register = 0.
- **Read latency:** request accepted at edge k; SRAM strobes active in cycle k..k+1; data captured at edge k+1; rvalid high in cycle k+1..k+2. That is 2 clk, i.e. 1 pixel.
- **Write:** accepted at edge k; we_n low for exactly one cycle after edge k.
- **Throughput:** the display has a guaranteed 1 access per pixel. The CPU is guaranteed at least 1 access per pixel, and gets 2 during blanking or when disp_req is low.
- **Reset mid-operation:** an in-flight read is dropped with no rvalid, and a pending swap is cleared.

## Test plan
- **Reset:** after rst_n deassertion, check phase alternation pix_en = 1,0,1,0… All strobes read 1 and front_buf = 0 before the first request.
- **Display reads:** disp_req held high with disp_addr incrementing from 0 in even slots. Expect sram_addr = {0, addr} in every even issue. disp_rvalid follows every 2 clk with sram_dq_i echoed two edges later.
- **Contention:** cpu_valid write held while disp_req is high. Expect cpu_ready only in odd slots, and we_n low only in odd-slot issue cycles. For cpu_be = 2'b01: ub_n = 1, lb_n = 0.
- **CPU-only:** disp_req = 0 with a CPU read stream. Expect a read every cycle, cpu_rvalid continuous, and sram_addr MSB = 1 (back buffer).
- **Buffer swap:** swap_req pulse mid-frame. Expect no change until the disp_vactive falling edge. Then front_buf = 1 and swap_done is a single pulse; disp addresses now use MSB 1 and CPU addresses MSB 0. A swap_req on the same cycle as the fall also swaps at that edge.
- **Reset mid-read:** assert rst_n low during ST_CRD. Expect no cpu_rvalid, and all outputs return to reset values asynchronously.
